// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding,
// per-state output decode and the counter width helper.
package pll_seq_pkg;

    // State encoding; also exported unchanged on state_dbg.
    localparam logic [2:0] PLL_RST   = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] FILTER    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    // Registered outputs that depend only on the state being entered.
    typedef struct packed {
        logic pll_rst;
        logic sys_reset;
        logic ready;
        logic fault;
    } state_out_t;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    // Output pattern for each state; unknown codes fall back to the safe reset pattern.
    function automatic state_out_t decode_outputs(input logic [2:0] st);
        state_out_t o;
        case (st)
            WAIT_LOCK,
            FILTER:  o = '{pll_rst: 1'b0, sys_reset: 1'b1, ready: 1'b0, fault: 1'b0};
            RUN:     o = '{pll_rst: 1'b0, sys_reset: 1'b0, ready: 1'b1, fault: 1'b0};
            FAULT:   o = '{pll_rst: 1'b1, sys_reset: 1'b1, ready: 1'b0, fault: 1'b1};
            default: o = '{pll_rst: 1'b1, sys_reset: 1'b1, ready: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops; cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so the second flop takes the first flop's pre-edge value.
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the system PLL from the reference clock: pulses the PLL reset,
// filters lock, holds the core in reset until lock is stable, retries a
// bounded number of times and then latches a fault until rst.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 1024,
    parameter int LOSS_FILTER    = 4,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                                refclk,
    input  logic                                rst,
    input  logic                                pll_locked,
    output logic                                pll_rst,
    output logic                                sys_reset,
    output logic                                ready,
    output logic                                fault,
    output logic [cnt_width(MAX_RETRIES)-1:0]   retry_cnt,
    output logic [2:0]                          state_dbg
);

    localparam int RST_W   = cnt_width(PLL_RST_CYCLES);
    localparam int TMR_W   = cnt_width(LOCK_TIMEOUT);
    localparam int FILT_W  = cnt_width(LOCK_FILTER);
    localparam int LOSS_W  = cnt_width(LOSS_FILTER);
    localparam int RETRY_W = cnt_width(MAX_RETRIES);

    // Terminal values: each counter advances until it sits on its last value.
    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic               lk_s;
    logic [2:0]         state,     state_nxt;
    logic [RST_W-1:0]   rst_cnt,   rst_cnt_nxt;
    logic [TMR_W-1:0]   timer,     timer_nxt;
    logic [FILT_W-1:0]  filt_cnt,  filt_cnt_nxt;
    logic [LOSS_W-1:0]  loss_cnt,  loss_cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    state_out_t         outs;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    // Next-state and counter update logic; every increment is guarded so counters saturate.
    always_comb begin
        // NOTE: hold every value by default so no branch leaves a latch behind.
        state_nxt    = state;
        rst_cnt_nxt  = rst_cnt;
        timer_nxt    = timer;
        filt_cnt_nxt = filt_cnt;
        loss_cnt_nxt = loss_cnt;
        retry_nxt    = retry_cnt;
        case (state)
            PLL_RST: begin
                if (rst_cnt >= RST_LAST) begin
                    state_nxt   = WAIT_LOCK;
                    rst_cnt_nxt = '0;
                    timer_nxt   = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    // Lock wins even on the timeout cycle.
                    state_nxt    = FILTER;
                    filt_cnt_nxt = FILT_W'(1);
                end else if (timer >= TMR_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt   = retry_cnt + 1'b1;
                        state_nxt   = PLL_RST;
                        rst_cnt_nxt = '0;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            FILTER: begin
                if (!lk_s) begin
                    // Timer keeps its value so the timeout bounds total acquisition time.
                    state_nxt = WAIT_LOCK;
                end else if (filt_cnt >= FILT_LAST) begin
                    state_nxt    = RUN;
                    retry_nxt    = '0;
                    loss_cnt_nxt = '0;
                end else begin
                    filt_cnt_nxt = filt_cnt + 1'b1;
                end
            end
            RUN: begin
                if (lk_s) begin
                    loss_cnt_nxt = '0;
                end else if (loss_cnt >= LOSS_LAST) begin
                    state_nxt    = WAIT_LOCK;
                    timer_nxt    = '0;
                    loss_cnt_nxt = '0;
                end else begin
                    loss_cnt_nxt = loss_cnt + 1'b1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt   = PLL_RST;
                rst_cnt_nxt = '0;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the state being entered.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            rst_cnt   <= '0;
            timer     <= '0;
            filt_cnt  <= '0;
            loss_cnt  <= '0;
            retry_cnt <= '0;
            outs      <= decode_outputs(PLL_RST);
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            timer     <= timer_nxt;
            filt_cnt  <= filt_cnt_nxt;
            loss_cnt  <= loss_cnt_nxt;
            retry_cnt <= retry_nxt;
            outs      <= decode_outputs(state_nxt);
        end
    end

    assign pll_rst   = outs.pll_rst;
    assign sys_reset = outs.sys_reset;
    assign ready     = outs.ready;
    assign fault     = outs.fault;
    assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: each scenario pushes the expected
// per-cycle output pattern, a negedge monitor pops and compares it.
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    typedef struct {
        int         cyc;
        string      tag;
        logic [8:0] val;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;
    int   mon_cyc;
    int   stim_cyc;
    bit   armed;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_FILTER    (8),
        .LOSS_FILTER    (2),
        .LOCK_TIMEOUT   (32),
        .MAX_RETRIES    (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg)
    );

    always #5 refclk = ~refclk;

    // Expected {pll_rst, sys_reset, ready, fault, retry_cnt, state} for a state.
    function automatic logic [8:0] ev(input logic [2:0] st, input logic [1:0] rc);
        logic [3:0] o;
        case (st)
            S_PLL_RST:   o = 4'b1100;
            S_WAIT_LOCK: o = 4'b0100;
            S_FILTER:    o = 4'b0100;
            S_RUN:       o = 4'b0010;
            default:     o = 4'b1101;
        endcase
        return {o, rc, st};
    endfunction

    function automatic logic [8:0] obs();
        return {pll_rst, sys_reset, ready, fault, retry_cnt, state_dbg};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_span(input string name, input int c0, input int c1,
                            input logic [2:0] st, input logic [1:0] rc);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            e.cyc = c;
            e.tag = $sformatf("%s_c%0d", name, c);
            e.val = ev(st, rc);
            sb.push_back(e);
        end
    endtask

    task automatic goto_cyc(input int c);
        repeat (c - stim_cyc) @(negedge refclk);
        stim_cyc = c;
    endtask

    // Called at a negedge; leaves the bench just after the edge ending cycle 0.
    task automatic do_reset();
        check("sb_empty", sb.size(), 0);
        armed = 1'b0;
        sb.delete();
        rst = 1'b1;
        @(negedge refclk);
        check("rst_outs", obs(), ev(S_PLL_RST, 2'd0));
        rst = 1'b0;
        @(posedge refclk);
        #1;
        mon_cyc  = 1;
        stim_cyc = 0;
        armed    = 1'b1;
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge refclk) begin
        if (armed) begin
            while (sb.size() > 0 && sb[0].cyc <= mon_cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.cyc < mon_cyc)
                    check({mon_e.tag, "_missed"}, mon_cyc, mon_e.cyc);
                else
                    check(mon_e.tag, obs(), mon_e.val);
            end
            mon_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pll_locked = 1'b0; armed = 1'b0;
        n_checks = 0; n_errors = 0; mon_cyc = 0; stim_cyc = 0;
        @(negedge refclk);
        do_reset();

        // Clean lock: pll_rst cycles 0-3, ready 8 cycles after lk_s rises.
        exp_span("s1_prst", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s1_wait", 4, 12, S_WAIT_LOCK, 2'd0);
        exp_span("s1_filt", 13, 19, S_FILTER, 2'd0);
        exp_span("s1_run", 20, 24, S_RUN, 2'd0);
        goto_cyc(10); pll_locked = 1'b1;
        goto_cyc(25); pll_locked = 1'b0;
        do_reset();

        // Lock never arrives: three attempts then sticky fault, cleared by rst.
        exp_span("s2_prst0", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s2_wait0", 4, 35, S_WAIT_LOCK, 2'd0);
        exp_span("s2_prst1", 36, 39, S_PLL_RST, 2'd1);
        exp_span("s2_wait1", 40, 71, S_WAIT_LOCK, 2'd1);
        exp_span("s2_prst2", 72, 75, S_PLL_RST, 2'd2);
        exp_span("s2_wait2", 76, 107, S_WAIT_LOCK, 2'd2);
        exp_span("s2_fault", 108, 130, S_FAULT, 2'd2);
        goto_cyc(131);
        do_reset();

        // One-cycle lock drop at filter count 5 forces a fresh filter run.
        exp_span("s3_prst", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s3_wait", 4, 12, S_WAIT_LOCK, 2'd0);
        exp_span("s3_filt", 13, 17, S_FILTER, 2'd0);
        exp_span("s3_rewait", 18, 18, S_WAIT_LOCK, 2'd0);
        exp_span("s3_refilt", 19, 25, S_FILTER, 2'd0);
        exp_span("s3_run", 26, 30, S_RUN, 2'd0);
        goto_cyc(10); pll_locked = 1'b1;
        goto_cyc(15); pll_locked = 1'b0;
        goto_cyc(16); pll_locked = 1'b1;
        goto_cyc(31); pll_locked = 1'b0;
        do_reset();

        // In RUN: 1-cycle glitch ignored, 2-cycle loss drops to WAIT_LOCK, relock.
        exp_span("s4_prst", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s4_wait", 4, 12, S_WAIT_LOCK, 2'd0);
        exp_span("s4_filt", 13, 19, S_FILTER, 2'd0);
        exp_span("s4_run", 20, 33, S_RUN, 2'd0);
        exp_span("s4_loss", 34, 34, S_WAIT_LOCK, 2'd0);
        exp_span("s4_refilt", 35, 41, S_FILTER, 2'd0);
        exp_span("s4_rerun", 42, 46, S_RUN, 2'd0);
        goto_cyc(10); pll_locked = 1'b1;
        goto_cyc(24); pll_locked = 1'b0;
        goto_cyc(25); pll_locked = 1'b1;
        goto_cyc(30); pll_locked = 1'b0;
        goto_cyc(32); pll_locked = 1'b1;
        goto_cyc(47); pll_locked = 1'b0;
        do_reset();

        // rst during FILTER; lock stays high so the restart filters straight away.
        exp_span("s5_prst", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s5_wait", 4, 12, S_WAIT_LOCK, 2'd0);
        exp_span("s5_filt", 13, 15, S_FILTER, 2'd0);
        goto_cyc(10); pll_locked = 1'b1;
        goto_cyc(16);
        do_reset();
        exp_span("s5b_prst", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s5b_wait", 4, 4, S_WAIT_LOCK, 2'd0);
        exp_span("s5b_filt", 5, 11, S_FILTER, 2'd0);
        exp_span("s5b_run", 12, 16, S_RUN, 2'd0);
        goto_cyc(17); pll_locked = 1'b0;
        do_reset();

        // Lock seen exactly on the timeout cycle of the first retry wait.
        exp_span("s6_prst0", 1, 3, S_PLL_RST, 2'd0);
        exp_span("s6_wait0", 4, 35, S_WAIT_LOCK, 2'd0);
        exp_span("s6_prst1", 36, 39, S_PLL_RST, 2'd1);
        exp_span("s6_wait1", 40, 71, S_WAIT_LOCK, 2'd1);
        exp_span("s6_filt", 72, 78, S_FILTER, 2'd1);
        exp_span("s6_run", 79, 83, S_RUN, 2'd0);
        goto_cyc(69); pll_locked = 1'b1;
        goto_cyc(84);
        check("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the core's system PLL (50 MHz reference in, 40/10 MHz out) from the reference-clock domain.
- Generates the PLL reset pulse and filters the PLL lock signal.
- Holds system reset asserted until the clocks are stable.
- On lock loss, re-asserts system reset; retries the PLL with a bounded retry count, then flags a sticky fault.
- Sits between the top-level reset source and the PLL wrapper; its outputs feed the core reset tree.

Parameters:
PLL_RST_CYCLES, 16, number of refclk cycles pll_rst is held high per PLL reset attempt (≥1)
LOCK_FILTER, 1024, consecutive synchronized-locked-high cycles required before release
LOSS_FILTER, 4, consecutive synchronized-locked-low cycles in RUN treated as lock loss (≥1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a PLL retry
MAX_RETRIES, 3, PLL reset retries after the initial attempt before FAULT

Ports:
refclk  in  1  reference clock (50 MHz), sole clock
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL lock, asynchronous to refclk
pll_rst  out  1  reset to PLL, active high, registered
sys_reset  out  1  core system reset, active high, registered
ready  out  1  high only in RUN
fault  out  1  sticky: retries exhausted
retry_cnt  out  $clog2(MAX_RETRIES+1)  retries consumed since last RUN
state_dbg  out  3  encoded current state

Behaviour:
Clock and reset
- One clock: refclk. Reset is synchronous and active-high on rst.
- While rst is high: state=PLL_RST, all counters=0, pll_rst=1, sys_reset=1, ready=0, fault=0, retry_cnt=0.
- rst mid-operation aborts any state on the next edge, including FAULT.

Lock synchronizer
- pll_locked passes a 2-flop synchronizer to give lk_s (2-cycle latency). All decisions use lk_s only.

State outputs (all outputs registered)
- PLL_RST: pll_rst=1, sys_reset=1.
- WAIT_LOCK: pll_rst=0, sys_reset=1.
- FILTER: pll_rst=0, sys_reset=1.
- RUN: pll_rst=0, sys_reset=0, ready=1.
- FAULT: pll_rst=1, sys_reset=1, fault=1.

Transitions
- PLL_RST: stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with timer cleared.
- WAIT_LOCK:
  - lk_s=1 → FILTER, filter count=1.
  - Otherwise the timer increments. At timer==LOCK_TIMEOUT-1 with lk_s=0:
    - retry_cnt<MAX_RETRIES → retry_cnt++, go to PLL_RST.
    - Else → FAULT.
  - lk_s=1 on the timeout cycle takes priority (goes to FILTER).
- FILTER:
  - lk_s=0 → WAIT_LOCK. Timer is NOT cleared (the timeout bounds total lock acquisition).
  - Count reaching LOCK_FILTER → RUN, retry_cnt cleared.
  - sys_reset falls on the first cycle ready=1.
- RUN:
  - lk_s low for LOSS_FILTER consecutive cycles → WAIT_LOCK, timer cleared.
  - sys_reset rises on the first cycle in WAIT_LOCK.
  - A shorter low glitch resets the loss counter with no output change.
- FAULT: terminal until rst.

Counters
- Counters saturate; they never wrap.
- Counter widths are sized with $clog2 of their limit + 1.

Decomposition:
- Package pll_seq_pkg: state enum (PLL_RST=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAULT=4; 3-bit, matches state_dbg) and a width helper function.
- Sub-module sync_2ff (1-bit, refclk): lock synchronizer, reusable elsewhere in the core.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_FILTER=8, LOSS_FILTER=2, LOCK_TIMEOUT=32, MAX_RETRIES=2.
1. Reset, then pll_locked=1 at cycle 10 → pll_rst high exactly cycles 0–3. ready rises 8 cycles after lk_s rises (lk_s rises 2 cycles after pll_locked). sys_reset falls the same cycle. retry_cnt=0.
2. pll_locked stuck 0 → three pll_rst pulses of 4 cycles each, spaced by 32-cycle waits. retry_cnt steps 0→1→2. Then fault=1 and pll_rst=1, held until rst.
3. In FILTER, pll_locked drops for 1 cycle at filter count 5 → returns to WAIT_LOCK and refilters. ready is delayed by a fresh 8 cycles after lk_s returns high.
4. In RUN: 1-cycle low on lk_s → no change. 2-cycle low → sys_reset=1, ready=0 on the next edge, no pll_rst pulse. Relock → ready after 8 filtered cycles.
5. rst pulsed during FILTER and again during FAULT → on the next edge all outputs return to reset values, and the sequence restarts from PLL_RST.
6. Lock arrives exactly on the timeout cycle (lk_s=1 at timer=31) → goes to FILTER, no retry, retry_cnt unchanged.
